layer_seq: RTL and testbench
============================

// Module: layer_seq
// PURPOSE
// Fully-connected-layer sequencer directly upstream of the dot accelerator: programs dot's
// Avalon slave once per output neuron, collects each dot product, adds a Q16.16 bias,
// applies optional ReLU, writes the activation to SDRAM. CPU programs it via its own slave port.
// PARAMETERS
// CNT_W       16  width of neuron counter (max n_out = 2**CNT_W-1)
// WORD_BYTES  4   byte stride between consecutive 32-bit words
// PORTS
// clk                   in   1   clock
// rst_n                 in   1   synchronous, active-HIGH reset (name as used across codebase)
// slave_waitrequest     out  1   CPU slave stall
// slave_address         in   4   CPU register index
// slave_read            in   1   CPU read
// slave_readdata        out  32  CPU read data
// slave_write           in   1   CPU write
// slave_writedata       in   32  CPU write data
// dot_waitrequest       in   1   stall from dot slave
// dot_address           out  4   dot register index
// dot_read / dot_write  out  1   dot accesses (never both high)
// dot_readdata          in   32  dot result; valid in cycle dot_read && !dot_waitrequest
// dot_writedata         out  32  dot config data
// mem_waitrequest       in   1   SDRAM stall
// mem_address           out  32  SDRAM byte address
// mem_read / mem_write  out  1   SDRAM accesses (never both high)
// mem_readdata          in   32  SDRAM read data
// mem_readdatavalid     in   1   SDRAM read data strobe
// mem_writedata         out  32  SDRAM write data
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, all CPU regs 0, i=0. Reset mid-run: masters drop next edge.
// - CPU regs: 0 W=start / R=blocking done; 1 R=neurons completed; 2 w_base; 3 if_addr;
//   4 bias_base; 5 n_words; 6 n_out; 7 out_base; 8 relu_en (bit0). Other addrs: R=0, W ignored.
// - slave_waitrequest high only for read of reg0 while busy; released in the cycle after DONE,
//   readdata 0. All other accesses complete same cycle, zero wait states.
// - Writes to regs 0,2-8 while busy are ignored; run uses the values present at start.
// - Every master holds address/data/strobe stable until its waitrequest is low at a clk edge.
// - FSM per neuron i (0..n_out-1):
//   IDLE --start--> (n_out==0 ? DONE : BIAS_RD)
//   BIAS_RD  mem_read @ bias_base+4i; after accept -> BIAS_WT
//   BIAS_WT  wait mem_readdatavalid, latch bias -> CFG_W
//   CFG_W    dot_write addr2 = wptr -> CFG_IF   (wptr starts w_base, += n_words*4 per neuron)
//   CFG_IF   dot_write addr3 = if_addr -> CFG_N
//   CFG_N    dot_write addr5 = n_words -> GO
//   GO       dot_write addr0 = 1 -> RES
//   RES      dot_read addr1; latch dot_readdata on accept -> ACT
//   ACT      sum = result + bias (32-bit two's-complement, wrap, no saturation);
//            act = (relu_en && sum[31]) ? 0 : sum -> WR
//   WR       mem_write @ out_base+4i, data act; after accept i++;
//            i==n_out ? DONE : BIAS_RD
//   DONE     one cycle, releases pending reg0 read -> IDLE
// - wptr via adder only, no multiplier; stride computed once at start (n_words<<2, wraps).
// - mem_readdatavalid outside BIAS_WT ignored. n_words==0 passed to dot unchanged.
// - Start written while idle with slave_read of reg0 in same cycle not possible (single port).
// STRUCTURE
// - layer_seq_pkg: state enum; LS_REG_* CPU map constants; DOT_REG_START=0, DOT_REG_RESULT=1,
//   DOT_REG_W=2, DOT_REG_IF=3, DOT_REG_N=5.
// - Sub-module bias_relu: combinational (result, bias, relu_en) -> act; unit-testable alone.
// TESTING
// - 1 neuron, w_base 0x1000, if 0x2000, n_words 4, bias 0x0001_0000, dot result 0x0002_0000,
//   relu 1 -> dot writes 2:0x1000,3:0x2000,5:4,0:1 in order; mem write 0x0003_0000 @ out_base.
// - 3 neurons, n_words 4 -> dot addr2 writes 0x1000,0x1010,0x1020; bias reads base+0,+4,+8;
//   outputs at out_base+0,+4,+8; reg1 reads 3.
// - result 0xFFFC_0000 + bias 0x0001_0000: relu 1 -> writes 0; relu 0 -> writes 0xFFFD_0000.
// - Random 0-5 cycle waitrequest on dot and mem, 1-8 cycle readdatavalid latency ->
//   identical data/order, strobes stable while stalled, never read+write together.
// - n_out=0 -> no master traffic, reg0 read returns within 2 cycles of start.
// - rst_n high mid-RES -> next edge all strobes 0; new start runs from neuron 0 correctly.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// Shared definitions for the fully-connected-layer sequencer.
//   state_t           sequencer FSM states
//   LS_REG_*          CPU-visible register indices of layer_seq
//   DOT_REG_*         register indices of the downstream dot accelerator
package layer_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BIAS_RD,
        ST_BIAS_WT,
        ST_CFG_W,
        ST_CFG_IF,
        ST_CFG_N,
        ST_GO,
        ST_RES,
        ST_ACT,
        ST_WR,
        ST_DONE
    } state_t;

    localparam logic [3:0] LS_REG_CTRL      = 4'd0;
    localparam logic [3:0] LS_REG_COUNT     = 4'd1;
    localparam logic [3:0] LS_REG_W_BASE    = 4'd2;
    localparam logic [3:0] LS_REG_IF_ADDR   = 4'd3;
    localparam logic [3:0] LS_REG_BIAS_BASE = 4'd4;
    localparam logic [3:0] LS_REG_N_WORDS   = 4'd5;
    localparam logic [3:0] LS_REG_N_OUT     = 4'd6;
    localparam logic [3:0] LS_REG_OUT_BASE  = 4'd7;
    localparam logic [3:0] LS_REG_RELU_EN   = 4'd8;

    localparam logic [3:0] DOT_REG_START  = 4'd0;
    localparam logic [3:0] DOT_REG_RESULT = 4'd1;
    localparam logic [3:0] DOT_REG_W      = 4'd2;
    localparam logic [3:0] DOT_REG_IF     = 4'd3;
    localparam logic [3:0] DOT_REG_N      = 4'd5;

endpackage

// File: rtl/bias_relu.sv
// Bias add and optional ReLU for one output neuron (purely combinational).
//   result   in  32  dot product from the accelerator (Q16.16)
//   bias     in  32  neuron bias (Q16.16)
//   relu_en  in  1   clamp negative sums to zero
//   act      out 32  activation; sum wraps in 32-bit two's complement
module bias_relu
    import layer_seq_pkg::*;
(
    input  logic [31:0] result,
    input  logic [31:0] bias,
    input  logic        relu_en,
    output logic [31:0] act
);

    logic [31:0] sum;

    always_comb begin
        sum = result + bias;
        act = (relu_en && sum[31]) ? '0 : sum;
    end

endmodule

// File: rtl/layer_seq.sv
// Fully-connected-layer sequencer. For each output neuron it fetches the bias
// from SDRAM, programs and starts the dot accelerator, reads back the dot
// product, applies bias + optional ReLU and writes the activation to SDRAM.
//   clk, rst_n            clock, synchronous active-high reset
//   slave_*               CPU register port (zero wait states except a
//                         blocking read of reg 0 while a run is active)
//   dot_*                 Avalon master towards the dot accelerator
//   mem_*                 Avalon master towards SDRAM (pipelined reads)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a start write to reg 0
// BIAS_RD  | mem_read of bias word for neuron i, held until accepted
// BIAS_WT  | waiting for mem_readdatavalid, latch bias
// CFG_W    | dot write: weight pointer
// CFG_IF   | dot write: input feature address
// CFG_N    | dot write: word count
// GO       | dot write: start
// RES      | dot read of result, latched on accept
// ACT      | bias add / ReLU, issue activation write
// WR       | mem_write of activation held until accepted, advance neuron
// DONE     | one cycle, then IDLE releases a stalled reg 0 read
module layer_seq
    import layer_seq_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WORD_BYTES = 4
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        dot_waitrequest,
    output logic [3:0]  dot_address,
    output logic        dot_read,
    output logic        dot_write,
    input  logic [31:0] dot_readdata,
    output logic [31:0] dot_writedata,
    input  logic        mem_waitrequest,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid,
    output logic [31:0] mem_writedata
);

    localparam int          WORD_SHIFT = $clog2(WORD_BYTES);
    localparam logic [31:0] WORD_STEP  = 32'(WORD_BYTES);

    state_t           state;
    logic [31:0]      w_base;
    logic [31:0]      if_addr;
    logic [31:0]      bias_base;
    logic [31:0]      n_words;
    logic [CNT_W-1:0] n_out;
    logic [31:0]      out_base;
    logic             relu_en;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      stride;
    logic [31:0]      wptr;
    logic [31:0]      bias_ptr;
    logic [31:0]      out_ptr;
    logic [31:0]      bias;
    logic [31:0]      result;
    logic [31:0]      act;

    logic             busy;
    logic             start;

    // DONE still counts as busy so a pending reg 0 read completes in the
    // cycle after DONE, once the FSM is back in IDLE.
    assign busy     = (state != ST_IDLE);
    assign start    = slave_write && !busy && (slave_address == LS_REG_CTRL);
    assign cnt_next = cnt + CNT_W'(1);

    assign slave_waitrequest = slave_read && busy && (slave_address == LS_REG_CTRL);

    always_comb begin
        slave_readdata = '0;
        case (slave_address)
            LS_REG_COUNT:     slave_readdata = 32'(cnt);
            LS_REG_W_BASE:    slave_readdata = w_base;
            LS_REG_IF_ADDR:   slave_readdata = if_addr;
            LS_REG_BIAS_BASE: slave_readdata = bias_base;
            LS_REG_N_WORDS:   slave_readdata = n_words;
            LS_REG_N_OUT:     slave_readdata = 32'(n_out);
            LS_REG_OUT_BASE:  slave_readdata = out_base;
            LS_REG_RELU_EN:   slave_readdata = {31'b0, relu_en};
            default:          slave_readdata = '0;
        endcase
    end

    // Configuration registers are frozen while a run is active, so the run
    // keeps using the values present at start without shadow copies.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            w_base    <= '0;
            if_addr   <= '0;
            bias_base <= '0;
            n_words   <= '0;
            n_out     <= '0;
            out_base  <= '0;
            relu_en   <= 1'b0;
        end else if (slave_write && !busy) begin
            case (slave_address)
                LS_REG_W_BASE:    w_base    <= slave_writedata;
                LS_REG_IF_ADDR:   if_addr   <= slave_writedata;
                LS_REG_BIAS_BASE: bias_base <= slave_writedata;
                LS_REG_N_WORDS:   n_words   <= slave_writedata;
                LS_REG_N_OUT:     n_out     <= slave_writedata[CNT_W-1:0];
                LS_REG_OUT_BASE:  out_base  <= slave_writedata;
                LS_REG_RELU_EN:   relu_en   <= slave_writedata[0];
                default: ;
            endcase
        end
    end

    bias_relu u_bias_relu (
        .result  (result),
        .bias    (bias),
        .relu_en (relu_en),
        .act     (act)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            stride        <= '0;
            wptr          <= '0;
            bias_ptr      <= '0;
            out_ptr       <= '0;
            bias          <= '0;
            result        <= '0;
            dot_address   <= '0;
            dot_read      <= 1'b0;
            dot_write     <= 1'b0;
            dot_writedata <= '0;
            mem_address   <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        stride   <= n_words << WORD_SHIFT;
                        wptr     <= w_base;
                        bias_ptr <= bias_base;
                        out_ptr  <= out_base;
                        if (n_out == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state       <= ST_BIAS_RD;
                            mem_read    <= 1'b1;
                            mem_address <= bias_base;
                        end
                    end
                end
                ST_BIAS_RD: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        state    <= ST_BIAS_WT;
                    end
                end
                ST_BIAS_WT: begin
                    if (mem_readdatavalid) begin
                        bias          <= mem_readdata;
                        dot_write     <= 1'b1;
                        dot_address   <= DOT_REG_W;
                        dot_writedata <= wptr;
                        state         <= ST_CFG_W;
                    end
                end
                ST_CFG_W: begin
                    if (!dot_waitrequest) begin
                        dot_address   <= DOT_REG_IF;
                        dot_writedata <= if_addr;
                        state         <= ST_CFG_IF;
                    end
                end
                ST_CFG_IF: begin
                    if (!dot_waitrequest) begin
                        dot_address   <= DOT_REG_N;
                        dot_writedata <= n_words;
                        state         <= ST_CFG_N;
                    end
                end
                ST_CFG_N: begin
                    if (!dot_waitrequest) begin
                        dot_address   <= DOT_REG_START;
                        dot_writedata <= 32'd1;
                        state         <= ST_GO;
                    end
                end
                ST_GO: begin
                    if (!dot_waitrequest) begin
                        dot_write     <= 1'b0;
                        dot_writedata <= '0;
                        dot_read      <= 1'b1;
                        dot_address   <= DOT_REG_RESULT;
                        state         <= ST_RES;
                    end
                end
                ST_RES: begin
                    if (!dot_waitrequest) begin
                        result   <= dot_readdata;
                        dot_read <= 1'b0;
                        state    <= ST_ACT;
                    end
                end
                ST_ACT: begin
                    mem_write     <= 1'b1;
                    mem_address   <= out_ptr;
                    mem_writedata <= act;
                    state         <= ST_WR;
                end
                ST_WR: begin
                    if (!mem_waitrequest) begin
                        mem_write <= 1'b0;
                        cnt       <= cnt_next;
                        wptr      <= wptr + stride;
                        bias_ptr  <= bias_ptr + WORD_STEP;
                        out_ptr   <= out_ptr + WORD_STEP;
                        if (cnt_next == n_out) begin
                            state <= ST_DONE;
                        end else begin
                            state       <= ST_BIAS_RD;
                            mem_read    <= 1'b1;
                            mem_address <= bias_ptr + WORD_STEP;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_seq.sv
// Scoreboard bench for layer_seq: stimulus pushes expected dot/mem transactions
// computed from the layer rules; slave models with random stalls and read
// latency pop and compare each accepted master transaction.
module tb_layer_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        dot_waitrequest;
    logic [3:0]  dot_address;
    logic        dot_read;
    logic        dot_write;
    logic [31:0] dot_readdata;
    logic [31:0] dot_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic [31:0] mem_writedata;

    layer_seq dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .slave_waitrequest (slave_waitrequest),
        .slave_address     (slave_address),
        .slave_read        (slave_read),
        .slave_readdata    (slave_readdata),
        .slave_write       (slave_write),
        .slave_writedata   (slave_writedata),
        .dot_waitrequest   (dot_waitrequest),
        .dot_address       (dot_address),
        .dot_read          (dot_read),
        .dot_write         (dot_write),
        .dot_readdata      (dot_readdata),
        .dot_writedata     (dot_writedata),
        .mem_waitrequest   (mem_waitrequest),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_writedata     (mem_writedata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } dot_txn_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_txn_t;

    dot_txn_t    exp_dot[$];
    mem_txn_t    exp_mem[$];
    logic [31:0] dot_res_q[$];
    logic [31:0] bias_mem[logic [31:0]];
    logic [31:0] res_arr[16];
    logic [31:0] bias_arr[16];

    int          tests = 0;
    int          fails = 0;
    int          traffic = 0;
    logic [31:0] last_mem_wdata = '0;

    bit          rd_pend = 1'b0;
    int          rd_lat = 0;
    logic [31:0] rd_data = '0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic log_dot(input bit wr, input logic [3:0] a, input logic [31:0] d);
        dot_txn_t e;
        tests++;
        if (exp_dot.size() == 0) begin
            fails++;
            $display("FAIL dot_unexpected: got wr=%0d addr %0d data 0x%08h, expected no access", wr, a, d);
        end else begin
            e = exp_dot.pop_front();
            if (e.wr != wr || e.addr !== a || (wr && e.data !== d)) begin
                fails++;
                $display("FAIL dot_txn: got wr=%0d addr %0d data 0x%08h expected wr=%0d addr %0d data 0x%08h",
                         wr, a, d, e.wr, e.addr, e.data);
            end
        end
    endtask

    task automatic log_mem(input bit wr, input logic [31:0] a, input logic [31:0] d);
        mem_txn_t e;
        tests++;
        if (wr) last_mem_wdata = d;
        if (exp_mem.size() == 0) begin
            fails++;
            $display("FAIL mem_unexpected: got wr=%0d addr 0x%08h data 0x%08h, expected no access", wr, a, d);
        end else begin
            e = exp_mem.pop_front();
            if (e.wr != wr || e.addr !== a || (wr && e.data !== d)) begin
                fails++;
                $display("FAIL mem_txn: got wr=%0d addr 0x%08h data 0x%08h expected wr=%0d addr 0x%08h data 0x%08h",
                         wr, a, d, e.wr, e.addr, e.data);
            end
        end
    endtask

    // Dot accelerator slave: 0-5 stall cycles per access, returns queued results.
    initial begin : dot_slave
        bit          active;
        int          stall;
        bit          stalled;
        logic [37:0] held;
        active = 1'b0; stall = 0; stalled = 1'b0; held = '0;
        dot_waitrequest = 1'b0;
        dot_readdata    = '0;
        forever begin
            @(negedge clk);
            if (dot_read && dot_write) begin
                tests++; fails++;
                $display("FAIL dot_rd_wr_both: got read=1 write=1 expected at most one");
            end
            if (stalled && !rst_n) begin
                tests++;
                if ({dot_read, dot_write, dot_address, dot_writedata} !== held) begin
                    fails++;
                    $display("FAIL dot_stable: got 0x%010h expected 0x%010h",
                             {dot_read, dot_write, dot_address, dot_writedata}, held);
                end
            end
            stalled = 1'b0;
            if (rst_n) begin
                active = 1'b0;
                dot_waitrequest = 1'b0;
            end else if (dot_read || dot_write) begin
                traffic++;
                if (!active) begin
                    active = 1'b1;
                    stall = int'($urandom_range(0, 5));
                end
                if (stall > 0) begin
                    stall--;
                    dot_waitrequest = 1'b1;
                    stalled = 1'b1;
                    held = {dot_read, dot_write, dot_address, dot_writedata};
                end else begin
                    dot_waitrequest = 1'b0;
                    active = 1'b0;
                    if (dot_read)
                        dot_readdata = (dot_res_q.size() != 0) ? dot_res_q.pop_front() : 32'hDEAD_BEEF;
                    log_dot(dot_write, dot_address, dot_writedata);
                end
            end else begin
                active = 1'b0;
                dot_waitrequest = 1'($urandom_range(0, 1));
                dot_readdata = $urandom;
            end
        end
    end

    // SDRAM slave: 0-5 stall cycles, 1-8 cycle read latency, stray readdatavalid pulses.
    initial begin : mem_slave
        bit          active;
        int          stall;
        bit          stalled;
        logic [65:0] held;
        active = 1'b0; stall = 0; stalled = 1'b0; held = '0;
        mem_waitrequest   = 1'b0;
        mem_readdata      = '0;
        mem_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            mem_readdatavalid = 1'b0;
            mem_readdata = $urandom;
            if (rd_pend) begin
                rd_lat--;
                if (rd_lat <= 0) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata = rd_data;
                    rd_pend = 1'b0;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_readdatavalid = 1'b1;
            end
            if (mem_read && mem_write) begin
                tests++; fails++;
                $display("FAIL mem_rd_wr_both: got read=1 write=1 expected at most one");
            end
            if (stalled && !rst_n) begin
                tests++;
                if ({mem_read, mem_write, mem_address, mem_writedata} !== held) begin
                    fails++;
                    $display("FAIL mem_stable: got 0x%017h expected 0x%017h",
                             {mem_read, mem_write, mem_address, mem_writedata}, held);
                end
            end
            stalled = 1'b0;
            if (rst_n) begin
                active = 1'b0;
                mem_waitrequest = 1'b0;
            end else if (mem_read || mem_write) begin
                traffic++;
                if (!active) begin
                    active = 1'b1;
                    stall = int'($urandom_range(0, 5));
                end
                if (stall > 0) begin
                    stall--;
                    mem_waitrequest = 1'b1;
                    stalled = 1'b1;
                    held = {mem_read, mem_write, mem_address, mem_writedata};
                end else begin
                    mem_waitrequest = 1'b0;
                    active = 1'b0;
                    if (mem_read) begin
                        rd_pend = 1'b1;
                        rd_lat  = int'($urandom_range(1, 8));
                        rd_data = bias_mem.exists(mem_address) ? bias_mem[mem_address] : 32'h0BAD_0BAD;
                    end
                    log_mem(mem_write, mem_address, mem_writedata);
                end
            end else begin
                active = 1'b0;
                mem_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(posedge clk);
        #1;
        slave_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        d = 'x;
        @(negedge clk);
        slave_address = a;
        slave_read    = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            #1;
            if (!slave_waitrequest) begin
                d  = slave_readdata;
                ok = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL cpu_read_timeout: addr %0d got stall after 5000 cycles expected completion", a);
        end
        @(posedge clk);
        #1;
        slave_read = 1'b0;
    endtask

    // Reference: neuron n uses weights at w_base + n*n_words*4, bias at
    // bias_base + 4n, output at out_base + 4n; act = relu(result + bias).
    task automatic push_expected(input logic [31:0] wb, input logic [31:0] ifa, input logic [31:0] bb,
                                 input logic [31:0] nw, input logic [31:0] ob, input int nout, input bit relu);
        for (int n = 0; n < nout; n++) begin
            logic [31:0] sum;
            logic [31:0] a;
            sum = res_arr[n] + bias_arr[n];
            a   = (relu && $signed(sum) < 0) ? 32'd0 : sum;
            bias_mem[bb + 32'(4 * n)] = bias_arr[n];
            dot_res_q.push_back(res_arr[n]);
            exp_mem.push_back('{wr: 1'b0, addr: bb + 32'(4 * n), data: 32'd0});
            exp_dot.push_back('{wr: 1'b1, addr: 4'd2, data: wb + 32'(n) * nw * 32'd4});
            exp_dot.push_back('{wr: 1'b1, addr: 4'd3, data: ifa});
            exp_dot.push_back('{wr: 1'b1, addr: 4'd5, data: nw});
            exp_dot.push_back('{wr: 1'b1, addr: 4'd0, data: 32'd1});
            exp_dot.push_back('{wr: 1'b0, addr: 4'd1, data: 32'd0});
            exp_mem.push_back('{wr: 1'b1, addr: ob + 32'(4 * n), data: a});
        end
    endtask

    task automatic program_and_start(input logic [31:0] wb, input logic [31:0] ifa, input logic [31:0] bb,
                                     input logic [31:0] nw, input logic [31:0] ob, input int nout, input bit relu);
        cpu_write(4'd2, wb);
        cpu_write(4'd3, ifa);
        cpu_write(4'd4, bb);
        cpu_write(4'd5, nw);
        cpu_write(4'd6, 32'(nout));
        cpu_write(4'd7, ob);
        cpu_write(4'd8, {31'b0, relu});
        push_expected(wb, ifa, bb, nw, ob, nout, relu);
        cpu_write(4'd0, 32'd1);
    endtask

    task automatic run_layer(input logic [31:0] wb, input logic [31:0] ifa, input logic [31:0] bb,
                             input logic [31:0] nw, input logic [31:0] ob, input int nout,
                             input bit relu, input bit poke_busy);
        logic [31:0] rd;
        int          w;
        program_and_start(wb, ifa, bb, nw, ob, nout, relu);
        if (poke_busy) begin
            cpu_write(4'd2, ~wb);
            cpu_write(4'd6, 32'd0);
        end
        cpu_read(4'd0, rd, w);
        check32("done_readdata", rd, 32'd0);
        cpu_read(4'd1, rd, w);
        check32("neurons_done", rd, 32'(nout));
        check32("dot_expected_left", 32'(exp_dot.size()), 32'd0);
        check32("mem_expected_left", 32'(exp_mem.size()), 32'd0);
        if (poke_busy) begin
            cpu_read(4'd2, rd, w);
            check32("busy_write_ignored", rd, wb);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish by 500000 ns expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] rd;
        int          w;
        int          t0;
        bit          found;

        rst_n = 1'b1;
        slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset_strobes", {28'd0, dot_read, dot_write, mem_read, mem_write}, 32'd0);
        check32("reset_mem_address", mem_address, 32'd0);
        check32("reset_outputs_misc", {dot_writedata ^ mem_writedata}, 32'd0);
        check32("reset_waitrequest", {31'd0, slave_waitrequest}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;

        for (int r = 1; r <= 8; r++) begin
            cpu_read(4'(r), rd, w);
            check32("reset_reg_value", rd, 32'd0);
        end

        // register readback, masked widths and unmapped addresses
        cpu_write(4'd2, 32'h1234_5678);
        cpu_write(4'd6, 32'h0001_0003);
        cpu_write(4'd8, 32'hFFFF_FFFF);
        cpu_write(4'd1, 32'h0000_0055);
        cpu_write(4'd9, 32'hAAAA_5555);
        cpu_read(4'd2, rd, w);  check32("reg_w_base", rd, 32'h1234_5678);
        cpu_read(4'd6, rd, w);  check32("reg_n_out_masked", rd, 32'd3);
        cpu_read(4'd8, rd, w);  check32("reg_relu_bit0", rd, 32'd1);
        cpu_read(4'd1, rd, w);  check32("reg_count_readonly", rd, 32'd0);
        cpu_read(4'd9, rd, w);  check32("reg_unmapped", rd, 32'd0);

        // single neuron, positive sum
        res_arr[0] = 32'h0002_0000; bias_arr[0] = 32'h0001_0000;
        run_layer(32'h1000, 32'h2000, 32'h4000, 32'd4, 32'h8000, 1, 1'b1, 1'b0);
        check32("one_neuron_out", last_mem_wdata, 32'h0003_0000);

        // three neurons, busy writes must be ignored
        for (int n = 0; n < 3; n++) begin res_arr[n] = $urandom; bias_arr[n] = $urandom; end
        run_layer(32'h1000, 32'h2000, 32'h4000, 32'd4, 32'h9000, 3, 1'b0, 1'b1);

        // negative sum with and without ReLU
        res_arr[0] = 32'hFFFC_0000; bias_arr[0] = 32'h0001_0000;
        run_layer(32'h100, 32'h200, 32'h300, 32'd8, 32'h400, 1, 1'b1, 1'b0);
        check32("relu_clamp", last_mem_wdata, 32'h0000_0000);
        res_arr[0] = 32'hFFFC_0000; bias_arr[0] = 32'h0001_0000;
        run_layer(32'h100, 32'h200, 32'h300, 32'd8, 32'h500, 1, 1'b0, 1'b0);
        check32("relu_off_negative", last_mem_wdata, 32'hFFFD_0000);

        // n_out == 0: no master traffic, fast completion
        t0 = traffic;
        cpu_write(4'd6, 32'd0);
        cpu_write(4'd0, 32'd1);
        cpu_read(4'd0, rd, w);
        tests++;
        if (w > 1) begin
            fails++;
            $display("FAIL nout0_latency: got %0d stall cycles expected at most 1", w);
        end
        check32("nout0_traffic", 32'(traffic - t0), 32'd0);

        // reset while waiting on the dot result
        for (int n = 0; n < 3; n++) begin res_arr[n] = $urandom; bias_arr[n] = $urandom; end
        program_and_start(32'h4000, 32'h5000, 32'h6000, 32'd16, 32'h7000, 3, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (dot_read) begin found = 1'b1; break; end
        end
        check32("reset_mid_res_reached", {31'd0, found}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check32("mid_reset_strobes", {28'd0, dot_read, dot_write, mem_read, mem_write}, 32'd0);
        check32("mid_reset_mem_address", mem_address, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        exp_dot.delete();
        exp_mem.delete();
        dot_res_q.delete();
        rd_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        cpu_read(4'd1, rd, w);  check32("mid_reset_count", rd, 32'd0);
        cpu_read(4'd7, rd, w);  check32("mid_reset_reg", rd, 32'd0);
        for (int n = 0; n < 3; n++) begin res_arr[n] = $urandom; bias_arr[n] = $urandom; end
        run_layer(32'h4000, 32'h5000, 32'h6000, 32'd16, 32'h7000, 3, 1'b1, 1'b0);

        // randomized layers
        for (int t = 0; t < 10; t++) begin
            int          nout;
            logic [31:0] nw;
            nout = int'($urandom_range(1, 6));
            nw   = (t == 0) ? 32'd0 : 32'($urandom_range(0, 64));
            for (int n = 0; n < nout; n++) begin res_arr[n] = $urandom; bias_arr[n] = $urandom; end
            run_layer($urandom & ~32'd3, $urandom, $urandom & ~32'd3, nw, $urandom & ~32'd3,
                      nout, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
